// File: rtl/video_timing_src.sv
// NES-style dot/line timing source with a small pixel FIFO feeding the video block.
// Optional odd-frame dot skip on the pre-render line: define VIDEO_TIMING_SRC_ODD_SKIP_EN.
module video_timing_src #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       render_en,
    input  logic [5:0] backdrop,
    input  logic       pix_valid,
    input  logic [5:0] pix_color,
    output logic       pix_ready,
    output logic [5:0] color,
    output logic [8:0] count_h,
    output logic [8:0] count_v,
    output logic       vblank,
    output logic       frame_odd,
    output logic       underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [5:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    logic        skip_dot;
    logic        line_end;
    logic [8:0]  h_nxt;
    logic [8:0]  v_nxt;
    logic        frame_start;
    logic        visible;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign pix_ready = reset_n & ~full;
    assign push      = pix_valid & pix_ready;

`ifdef VIDEO_TIMING_SRC_ODD_SKIP_EN
    assign skip_dot = (count_v == 9'd511) && (count_h == 9'd339) && frame_odd && render_en;
`else
    logic unused_render_en;
    assign unused_render_en = render_en;
    assign skip_dot         = 1'b0;
`endif

    always_comb begin
        line_end = (count_h == 9'd340) || skip_dot;
        h_nxt    = line_end ? 9'd0 : count_h + 9'd1;
        v_nxt    = count_v;
        if (line_end) begin
            case (count_v)
                9'd260:  v_nxt = 9'd511;
                9'd511:  v_nxt = 9'd0;
                default: v_nxt = count_v + 9'd1;
            endcase
        end
        frame_start = line_end && (count_v == 9'd511);
        visible     = (h_nxt < 9'd256) && (v_nxt < 9'd240);
        pop         = ce & visible & ~empty;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= pix_color;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_h   <= 9'd0;
            count_v   <= 9'd511;
            color     <= 6'd0;
            vblank    <= 1'b0;
            frame_odd <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (ce) begin
                count_h <= h_nxt;
                count_v <= v_nxt;
                if (frame_start) begin
                    frame_odd <= ~frame_odd;
                end
                // Color is registered alongside the counters it describes.
                if (visible && !empty) begin
                    color <= mem[rd_ptr[AW-1:0]];
                end else begin
                    color <= backdrop;
                end
                if (visible && empty) begin
                    underrun <= 1'b1;
                end else if ((h_nxt == 9'd0) && (v_nxt == 9'd511)) begin
                    underrun <= 1'b0;
                end
                if ((h_nxt == 9'd1) && (v_nxt == 9'd241)) begin
                    vblank <= 1'b1;
                end else if ((h_nxt == 9'd1) && (v_nxt == 9'd511)) begin
                    vblank <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_video_timing_src.sv
// Randomized scoreboard bench for video_timing_src against a frame-position reference model.
`timescale 1ns/1ps
module tb_video_timing_src;

    localparam int DEPTH = 16;
    localparam int LINE  = 341;
    localparam int FRAME = 89342;
`ifdef VIDEO_TIMING_SRC_ODD_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ce;
    logic       render_en;
    logic [5:0] backdrop;
    logic       pix_valid;
    logic [5:0] pix_color;
    logic       pix_ready;
    logic [5:0] color;
    logic [8:0] count_h;
    logic [8:0] count_v;
    logic       vblank;
    logic       frame_odd;
    logic       underrun;

    video_timing_src #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .render_en(render_en),
        .backdrop(backdrop), .pix_valid(pix_valid), .pix_color(pix_color),
        .pix_ready(pix_ready), .color(color), .count_h(count_h), .count_v(count_v),
        .vblank(vblank), .frame_odd(frame_odd), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] col;
        logic [8:0] h;
        logic [8:0] v;
        logic       vb;
        logic       odd;
        logic       und;
        logic       rdy;
        logic       cev;
        logic       rst;
    } exp_t;

    exp_t       exp_q[$];
    logic [5:0] fq[$];

    // Reference state: position within the frame, rows ordered 511,0,1,...,260.
    int         m_p;
    logic       m_odd, m_vb, m_und;
    logic [5:0] m_col;

    int total = 0;
    int bad   = 0;
    int phase = 0;
    int ce_issued = 0;
    int vb_rises = 0;
    bit frame_hit = 0;
    bit hit32 = 0;
    bit hit_stale = 0;

    function automatic int pos_h(input int p);
        return p % LINE;
    endfunction

    function automatic int pos_v(input int p);
        return (p / LINE == 0) ? 511 : (p / LINE) - 1;
    endfunction

    task automatic model_dot(input logic ren, input logic [5:0] bd);
        int np;
        int nh;
        int nv;
        np = m_p + 1;
        if (SKIP_EN && m_p == LINE - 2 && m_odd && ren) np = LINE;
        if (np == FRAME) np = 0;
        if (np == LINE) m_odd = ~m_odd;
        m_p = np;
        nh  = pos_h(np);
        nv  = pos_v(np);
        if (nh < 256 && nv < 240) begin
            if (fq.size() > 0) m_col = fq.pop_front();
            else begin
                m_col = bd;
                m_und = 1'b1;
            end
        end else begin
            m_col = bd;
            if (nh == 0 && nv == 511) m_und = 1'b0;
        end
        if (nh == 1 && nv == 241) m_vb = 1'b1;
        if (nh == 1 && nv == 511) m_vb = 1'b0;
    endtask

    task automatic drive(input logic r, input logic c, input logic ren, input logic [5:0] bd,
                         input logic pv, input logic [5:0] pc);
        exp_t e;
        logic ready0;
        @(negedge clk);
        reset_n = r; ce = c; render_en = ren; backdrop = bd; pix_valid = pv; pix_color = pc;
        ready0 = r && (fq.size() < DEPTH);
        if (!r) begin
            m_p = 0; m_odd = 1'b0; m_vb = 1'b0; m_und = 1'b0; m_col = 6'd0;
            fq.delete();
            ce_issued = 0;
        end else begin
            if (c) begin
                model_dot(ren, bd);
                ce_issued++;
            end
            if (pv && ready0) fq.push_back(pc);
        end
        e.col = m_col;
        e.h   = 9'(pos_h(m_p));
        e.v   = 9'(pos_v(m_p));
        e.vb  = m_vb;
        e.odd = m_odd;
        e.und = m_und;
        e.rdy = r && (fq.size() < DEPTH);
        e.cev = r && c;
        e.rst = !r;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every registered output against the queued expectation.
    initial begin : monitor
        exp_t e;
        int   ce_cnt;
        logic prev_vb;
        ce_cnt  = 0;
        prev_vb = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({color, count_h, count_v, vblank, frame_odd, underrun, pix_ready} !==
                    {e.col, e.h, e.v, e.vb, e.odd, e.und, e.rdy}) begin
                    bad++;
                    $display("FAIL dot t=%0t got col=%h h=%0d v=%0d vb=%b odd=%b und=%b rdy=%b want col=%h h=%0d v=%0d vb=%b odd=%b und=%b rdy=%b",
                             $time, color, count_h, count_v, vblank, frame_odd, underrun, pix_ready,
                             e.col, e.h, e.v, e.vb, e.odd, e.und, e.rdy);
                end
                if (e.rst) begin
                    ce_cnt  = 0;
                    prev_vb = 1'b0;
                end else if (e.cev) begin
                    ce_cnt++;
                    if (phase == 2 && ce_cnt == FRAME) begin
                        frame_hit = 1;
                        total++;
                        if (count_h !== 9'd0 || count_v !== 9'd511) begin
                            bad++;
                            $display("FAIL frame_len got h=%0d v=%0d want h=0 v=511", count_h, count_v);
                        end
                    end
                    if (phase == 2 && !hit32 && count_v == 9'd0 && count_h == 9'd16) begin
                        hit32 = 1;
                        total++;
                        if (color !== 6'h0F || underrun !== 1'b1) begin
                            bad++;
                            $display("FAIL first_underrun got col=%h und=%b want col=0f und=1", color, underrun);
                        end
                    end
                    if (phase == 1 && !hit_stale && count_v == 9'd0 && count_h == 9'd0) begin
                        hit_stale = 1;
                        total++;
                        if (color !== 6'h0F || underrun !== 1'b1) begin
                            bad++;
                            $display("FAIL stale_pixel got col=%h und=%b want col=0f und=1", color, underrun);
                        end
                    end
                end
                if (vblank && !prev_vb) begin
                    vb_rises++;
                    total++;
                    if (count_h !== 9'd1 || count_v !== 9'd241) begin
                        bad++;
                        $display("FAIL vblank_rise got h=%0d v=%0d want h=1 v=241", count_h, count_v);
                    end
                end
                prev_vb = vblank;
            end
        end
    end

    initial begin : driver
        reset_n = 1'b0; ce = 1'b0; render_en = 1'b0; backdrop = 6'h0F;
        pix_valid = 1'b0; pix_color = 6'd0;
        m_p = 0; m_odd = 1'b0; m_vb = 1'b0; m_und = 1'b0; m_col = 6'd0;

        // Reset with ce toggling, then mid-line reset holding queued pixels.
        phase = 1;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'($urandom_range(0, 1)), 1'b1, 6'h0F, 1'b1, 6'h2A);
        for (int i = 0; i < 100; i++) drive(1'b1, 1'b1, 1'b1, 6'h0F, 1'b0, 6'h00);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, 6'h0F, 1'b1, 6'(6'h20 + i));
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 1'b1, 6'h0F, 1'b0, 6'h00);
        for (int i = 0; i < LINE + 4; i++) drive(1'b1, 1'b1, 1'b1, 6'h0F, 1'b0, 6'h00);

        // Full frame from reset: preload 1..16, overfill attempts refused, then random traffic.
        phase = 0;
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b1, 6'h0F, 1'b0, 6'h00);
        phase = 2;
        for (int i = 1; i <= DEPTH; i++) drive(1'b1, 1'b0, 1'b1, 6'h0F, 1'b1, 6'(i));
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 6'h0F, 1'b1, 6'h3F);
        for (int i = 0; i < LINE + 20; i++) drive(1'b1, 1'b1, 1'b1, 6'h0F, 1'b0, 6'h00);
        for (int i = 0; i < 3000; i++)
            drive(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  6'($urandom_range(0, 63)), 1'($urandom_range(0, 9) != 0), 6'($urandom_range(0, 63)));
        while (ce_issued < FRAME + 5)
            drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                  1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b1, 6'h0F, 1'b0, 6'h00);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d want 0", exp_q.size());
        end
        total++;
        if (vb_rises != 1) begin
            bad++;
            $display("FAIL vblank_count got %0d want 1", vb_rises);
        end
        total++;
        if (!frame_hit || !hit32 || !hit_stale) begin
            bad++;
            $display("FAIL checkpoints got frame=%0d first_underrun=%0d stale=%0d want 1 1 1",
                     frame_hit, hit32, hit_stale);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
